// File: rtl/inst_fetch.sv
// Instruction fetch: in-order imem requests capped by a credit of DEPTH, returned words buffered as {pc, inst}.
// First if_valid two cycles after reset with a 1-cycle memory; stall holds the head, branch flushes and kills in-flight words.
module sync_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_flush,
   input  logic                    i_push_vld,
   input  logic [W-1:0]            i_push_dat,
   input  logic                    i_pop_vld,
   output logic [W-1:0]            o_head_dat,
   output logic [$clog2(DEPTH):0]  o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push_vld) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (i_pop_vld)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(i_push_vld) - CW'(i_pop_vld);
      end
   end

   always_ff @(posedge clk) begin
      if (i_push_vld && !i_flush) r_mem[r_wr_ptr] <= i_push_dat;
   end

   assign o_head_dat = r_mem[r_rd_ptr];
   assign o_count    = r_count;
endmodule

module inst_fetch #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                DEPTH    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              branch_flag,
   input  logic [ADDR_W-1:0] branch_target,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic              imem_rvalid,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic [ADDR_W-1:0] if_pc,
   output logic [DATA_W-1:0] if_inst,
   output logic              if_valid
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int SW = CW + 1;
   localparam int EW = ADDR_W + DATA_W;

   logic [ADDR_W-1:0] r_fetch_pc;
   logic [CW-1:0]     r_kill_cnt;

   logic [CW-1:0]     w_tag_cnt;
   logic [CW-1:0]     w_fifo_cnt;
   logic [ADDR_W-1:0] w_tag_head;
   logic [EW-1:0]     w_fifo_head;
   logic [SW-1:0]     w_inflight;
   logic              w_credit_ok;
   logic              w_hs;
   logic              w_rsp_vld;
   logic              w_kill;
   logic              w_push_vld;
   logic              w_pop_vld;

   assign if_valid  = (w_fifo_cnt != '0);
   assign w_pop_vld = if_valid & ~stall & ~branch_flag;

   // The slot freed by this cycle's pop counts as free, so a 2-deep buffer sustains one fetch per cycle.
   assign w_inflight  = SW'(w_tag_cnt) + SW'(w_fifo_cnt) - SW'(w_pop_vld);
   assign w_credit_ok = (w_inflight < SW'(DEPTH));

   assign imem_req  = rst & ~branch_flag & w_credit_ok;
   assign imem_addr = rst ? r_fetch_pc : '0;
   assign w_hs      = imem_req & imem_ready;

   assign w_rsp_vld  = imem_rvalid & (w_tag_cnt != '0);
   assign w_kill     = w_rsp_vld & (branch_flag | (r_kill_cnt != '0));
   assign w_push_vld = w_rsp_vld & ~w_kill;

   assign if_pc   = if_valid ? w_fifo_head[EW-1 -: ADDR_W] : '0;
   assign if_inst = if_valid ? w_fifo_head[DATA_W-1:0]    : '0;

   sync_fifo #(.W(ADDR_W), .DEPTH(DEPTH)) u_tag_q (
      .clk        (clk),
      .rst        (rst),
      .i_flush    (1'b0),
      .i_push_vld (w_hs),
      .i_push_dat (r_fetch_pc),
      .i_pop_vld  (w_rsp_vld),
      .o_head_dat (w_tag_head),
      .o_count    (w_tag_cnt)
   );

   sync_fifo #(.W(EW), .DEPTH(DEPTH)) u_inst_q (
      .clk        (clk),
      .rst        (rst),
      .i_flush    (branch_flag),
      .i_push_vld (w_push_vld),
      .i_push_dat ({w_tag_head, imem_rdata}),
      .i_pop_vld  (w_pop_vld),
      .o_head_dat (w_fifo_head),
      .o_count    (w_fifo_cnt)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fetch_pc <= RESET_PC;
         r_kill_cnt <= '0;
      end else begin
         if (branch_flag)
            r_fetch_pc <= branch_target & ~ADDR_W'(3);
         else if (w_hs)
            r_fetch_pc <= r_fetch_pc + ADDR_W'(4);

         // Whatever is still in flight after a branch is wrong-path.
         if (branch_flag)
            r_kill_cnt <= w_tag_cnt - CW'(w_rsp_vld);
         else if (w_rsp_vld && (r_kill_cnt != '0))
            r_kill_cnt <= r_kill_cnt - CW'(1);
      end
   end
endmodule
